// File: rtl/torus_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for torus_raymarch.
// Build with TORUS_EARLY_EXIT_EN defined to end a march on its first hit.
package torus_pkg;

    localparam int Q_ONE     = 256;
    localparam int DIR_ONE   = 16384;
    localparam int LIGHT_ONE = 4096;

    // Internal datapath width: holds a gain-inflated CORDIC magnitude of two 16-bit values.
    localparam int IW = 20;

    localparam logic signed [IW-1:0] R_MAJOR = 20'sd512;
    localparam logic signed [IW-1:0] R_MINOR = 20'sd256;
    localparam logic signed [IW-1:0] HIT_EPS = 20'sd8;
    localparam logic [3:0]           MAX_STEPS     = 4'd12;
    localparam int                   CORDIC_STAGES = 8;
    localparam int                   DIR_SHIFT     = 14;

`ifdef TORUS_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t MARCH = 2'd1;
    localparam state_t DONE  = 2'd2;

    // Stage i shifts by i; no angle accumulator is needed for magnitude-only vectoring.
    function automatic int cordic_shift(input int stage);
        return stage;
    endfunction

    // x*(1/2+1/8-1/64) ~= x/1.6467, undoing the 8-stage CORDIC gain.
    function automatic logic signed [IW-1:0] gain_comp(input logic signed [IW-1:0] x);
        return (x >>> 1) + (x >>> 3) - (x >>> 6);
    endfunction

    function automatic logic signed [IW-1:0] sx16(input logic signed [15:0] v);
        return {{(IW-16){v[15]}}, v};
    endfunction

    function automatic logic signed [31:0] sx16_32(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic signed [31:0] sx20_32(input logic signed [IW-1:0] v);
        return {{(32-IW){v[IW-1]}}, v};
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        logic signed [15:0] r;
        if (v > 32'sd32767) begin
            r = 16'sd32767;
        end else if (v < -32'sd32767) begin
            r = -16'sd32767;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/torus_raymarch_cordic_len.sv
// Combinational CORDIC vectoring of (x,y): returns the gain-inflated magnitude and
// the x component of a companion vector rotated by the same angle.
module cordic_len
    import torus_pkg::*;
(
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic signed [IW-1:0] cx_i,
    input  logic signed [IW-1:0] cy_i,
    output logic signed [IW-1:0] mag_o,
    output logic signed [IW-1:0] cx_o
);

    logic signed [IW-1:0] xs  [0:CORDIC_STAGES];
    logic signed [IW-1:0] ys  [0:CORDIC_STAGES];
    logic signed [IW-1:0] cxs [0:CORDIC_STAGES];
    logic signed [IW-1:0] cys [0:CORDIC_STAGES];
    logic                 flip_s;

    // A left-half-plane vector is turned by 180 degrees (companion too) to stay in CORDIC range.
    assign flip_s = x_i[IW-1];
    assign xs[0]  = flip_s ? -x_i  : x_i;
    assign ys[0]  = flip_s ? -y_i  : y_i;
    assign cxs[0] = flip_s ? -cx_i : cx_i;
    assign cys[0] = flip_s ? -cy_i : cy_i;

    for (genvar i = 0; i < CORDIC_STAGES; i++) begin : g_stage
        assign xs[i+1]  = ys[i][IW-1] ? xs[i]  - (ys[i]  >>> cordic_shift(i))
                                      : xs[i]  + (ys[i]  >>> cordic_shift(i));
        assign ys[i+1]  = ys[i][IW-1] ? ys[i]  + (xs[i]  >>> cordic_shift(i))
                                      : ys[i]  - (xs[i]  >>> cordic_shift(i));
        assign cxs[i+1] = ys[i][IW-1] ? cxs[i] - (cys[i] >>> cordic_shift(i))
                                      : cxs[i] + (cys[i] >>> cordic_shift(i));
        assign cys[i+1] = ys[i][IW-1] ? cys[i] + (cxs[i] >>> cordic_shift(i))
                                      : cys[i] - (cxs[i] >>> cordic_shift(i));
    end

    assign mag_o = xs[CORDIC_STAGES];
    assign cx_o  = cxs[CORDIC_STAGES];

endmodule

// File: rtl/torus_raymarch.sv
// Sphere-traces a z-axis torus for one ray per start pulse and returns hit plus N.L.
// Optional TORUS_EARLY_EXIT_EN ends the march on the first hit; otherwise latency is fixed.
module torus_raymarch
    import torus_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [15:0] pxin,
    input  logic signed [15:0] pyin,
    input  logic signed [15:0] pzin,
    input  logic signed [15:0] rxin,
    input  logic signed [15:0] ryin,
    input  logic signed [15:0] rzin,
    input  logic signed [15:0] lxin,
    input  logic signed [15:0] lyin,
    input  logic signed [15:0] lzin,
    output logic               hit,
    output logic signed [15:0] light,
    output logic               valid
);

    state_t             state_q, state_d;
    logic [3:0]         step_q, step_d;
    logic signed [15:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic signed [15:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic signed [15:0] lx_q, lx_d, ly_q, ly_d, lz_q, lz_d;
    logic               found_q, found_d;
    logic signed [15:0] nl_q, nl_d;
    logic               hit_q, hit_d;
    logic signed [15:0] light_q, light_d;
    logic               valid_q, valid_d;

    logic signed [IW-1:0] mag1_s, lrot1_s, a_s, lrot1c_s;
    logic signed [IW-1:0] mag2_s, nlraw_s, d_s;
    logic signed [15:0]   nl_s, pxn_s, pyn_s, pzn_s, flight_s;
    logic signed [31:0]   d32_s, mx_s, my_s, mz_s;
    logic                 is_hit_s, last_s, fhit_s, done_s;

    // Pass 1: radial distance in the xy plane, light rotated onto the radial direction.
    cordic_len u_pass1 (
        .x_i   (sx16(px_q)),
        .y_i   (sx16(py_q)),
        .cx_i  (sx16(lx_q)),
        .cy_i  (sx16(ly_q)),
        .mag_o (mag1_s),
        .cx_o  (lrot1_s)
    );

    assign a_s      = gain_comp(mag1_s) - R_MAJOR;
    assign lrot1c_s = gain_comp(lrot1_s);

    // Pass 2: distance from the tube centre circle; rotated light x is N.L.
    cordic_len u_pass2 (
        .x_i   (a_s),
        .y_i   (sx16(pz_q)),
        .cx_i  (lrot1c_s),
        .cy_i  (sx16(lz_q)),
        .mag_o (mag2_s),
        .cx_o  (nlraw_s)
    );

    // Per-iteration datapath: signed distance, hit test and the next ray position.
    always_comb begin
        d_s      = gain_comp(mag2_s) - R_MINOR;
        nl_s     = sat16(sx20_32(gain_comp(nlraw_s)));
        is_hit_s = (d_s < HIT_EPS);
        last_s   = (step_q == (MAX_STEPS - 4'd1));
        d32_s    = sx20_32(d_s);
        mx_s     = d32_s * sx16_32(rx_q);
        my_s     = d32_s * sx16_32(ry_q);
        mz_s     = d32_s * sx16_32(rz_q);
        pxn_s    = sat16(sx16_32(px_q) + (mx_s >>> DIR_SHIFT));
        pyn_s    = sat16(sx16_32(py_q) + (my_s >>> DIR_SHIFT));
        pzn_s    = sat16(sx16_32(pz_q) + (mz_s >>> DIR_SHIFT));
        fhit_s   = found_q | is_hit_s;
        if (found_q) begin
            flight_s = nl_q;
        end else if (is_hit_s) begin
            flight_s = nl_s;
        end else begin
            flight_s = 16'sd0;
        end
        done_s   = last_s | (EARLY_EXIT & is_hit_s);
    end

    // Next-state logic; start reloads the query from any state and suppresses that cycle's result.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        px_d = px_q;  py_d = py_q;  pz_d = pz_q;
        rx_d = rx_q;  ry_d = ry_q;  rz_d = rz_q;
        lx_d = lx_q;  ly_d = ly_q;  lz_d = lz_q;
        found_d = found_q;
        nl_d    = nl_q;
        hit_d   = hit_q;
        light_d = light_q;
        valid_d = 1'b0;
        if (start) begin
            px_d = pxin;  py_d = pyin;  pz_d = pzin;
            rx_d = rxin;  ry_d = ryin;  rz_d = rzin;
            lx_d = lxin;  ly_d = lyin;  lz_d = lzin;
            step_d  = 4'd0;
            found_d = 1'b0;
            nl_d    = 16'sd0;
            state_d = MARCH;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                MARCH: begin
                    if (!found_q && is_hit_s) begin
                        found_d = 1'b1;
                        nl_d    = nl_s;
                    end else begin
                        found_d = found_q;
                    end
                    if (done_s) begin
                        hit_d   = fhit_s;
                        light_d = flight_s;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        step_d = step_q + 4'd1;
                        // A ray that has hit parks at the surface for the rest of a fixed-length march.
                        if (!fhit_s) begin
                            px_d = pxn_s;
                            py_d = pyn_s;
                            pz_d = pzn_s;
                        end else begin
                            px_d = px_q;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, query and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            px_q <= 16'sd0;  py_q <= 16'sd0;  pz_q <= 16'sd0;
            rx_q <= 16'sd0;  ry_q <= 16'sd0;  rz_q <= 16'sd0;
            lx_q <= 16'sd0;  ly_q <= 16'sd0;  lz_q <= 16'sd0;
            found_q <= 1'b0;
            nl_q    <= 16'sd0;
            hit_q   <= 1'b0;
            light_q <= 16'sd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            px_q <= px_d;  py_q <= py_d;  pz_q <= pz_d;
            rx_q <= rx_d;  ry_q <= ry_d;  rz_q <= rz_d;
            lx_q <= lx_d;  ly_q <= ly_d;  lz_q <= lz_d;
            found_q <= found_d;
            nl_q    <= nl_d;
            hit_q   <= hit_d;
            light_q <= light_d;
            valid_q <= valid_d;
        end
    end

    assign hit   = hit_q;
    assign light = light_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_torus_raymarch.sv
// Scoreboard bench for torus_raymarch: directed rays with hand-derived results plus
// random rays checked against an independent fixed-point model.
`timescale 1ns/1ps
module tb_torus_raymarch;

    localparam int MAXS = 12;
`ifdef TORUS_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int HEAD_LAT = EARLY ? 3 : 13;
    localparam int MISS_LAT = 13;
    localparam int LTOL     = 82;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed [15:0] pxin = 16'sd0, pyin = 16'sd0, pzin = 16'sd0;
    logic signed [15:0] rxin = 16'sd0, ryin = 16'sd0, rzin = 16'sd0;
    logic signed [15:0] lxin = 16'sd0, lyin = 16'sd0, lzin = 16'sd0;
    logic               hit;
    logic signed [15:0] light;
    logic               valid;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int hit;
        int light;
        int tol;
        int exp_cyc;
        int tag;
    } exp_t;
    exp_t sb[$];

    torus_raymarch dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pxin(pxin), .pyin(pyin), .pzin(pzin),
        .rxin(rxin), .ryin(ryin), .rzin(rzin),
        .lxin(lxin), .lyin(lyin), .lzin(lzin),
        .hit(hit), .light(light), .valid(valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp, input int tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic int comp(input int x);
        return (x >>> 1) + (x >>> 3) - (x >>> 6);
    endfunction

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    function automatic void cordic(input int x_in, input int y_in, input int cx_in,
                                   input int cy_in, output int mag, output int cxo);
        int x, y, cx, cy, xn, cxn;
        x = x_in; y = y_in; cx = cx_in; cy = cy_in;
        if (x < 0) begin
            x = -x; y = -y; cx = -cx; cy = -cy;
        end
        for (int i = 0; i < 8; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i);  y = y - (x >>> i);
                cxn = cx + (cy >>> i); cy = cy - (cx >>> i);
            end else begin
                xn = x - (y >>> i);  y = y + (x >>> i);
                cxn = cx - (cy >>> i); cy = cy + (cx >>> i);
            end
            x = xn; cx = cxn;
        end
        mag = x; cxo = cx;
    endfunction

    function automatic void model(input int px, input int py, input int pz,
                                  input int rx, input int ry, input int rz,
                                  input int lx, input int ly, input int lz,
                                  output int mhit, output int mlight, output int mlat);
        int mag, rl, a, l1, d, nl;
        mhit = 0; mlight = 0; mlat = MAXS + 1;
        for (int s = 0; s < MAXS; s++) begin
            cordic(px, py, lx, ly, mag, rl);
            a  = comp(mag) - 512;
            l1 = comp(rl);
            cordic(a, pz, l1, lz, mag, rl);
            d  = comp(mag) - 256;
            nl = sat(comp(rl));
            if (d < 8) begin
                mhit = 1; mlight = nl;
                if (EARLY) mlat = s + 2;
                break;
            end
            px = sat(px + ((d * rx) >>> 14));
            py = sat(py + ((d * ry) >>> 14));
            pz = sat(pz + ((d * rz) >>> 14));
        end
    endfunction

    task automatic issue(input int px, input int py, input int pz,
                         input int rx, input int ry, input int rz,
                         input int lx, input int ly, input int lz,
                         input int ehit, input int elight, input int etol, input int elat,
                         input bit abort_ok, input int tag);
        exp_t e;
        @(negedge clk);
        if (abort_ok) begin
            while (sb.size() > 0 && sb[$].exp_cyc >= cyc + 1) void'(sb.pop_back());
        end else begin
            check("valid_before_next_start", sb.size(), 0, 0);
        end
        pxin = 16'(px); pyin = 16'(py); pzin = 16'(pz);
        rxin = 16'(rx); ryin = 16'(ry); rzin = 16'(rz);
        lxin = 16'(lx); lyin = 16'(ly); lzin = 16'(lz);
        start = 1'b1;
        e.hit = ehit; e.light = elight; e.tol = etol; e.exp_cyc = cyc + elat; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        pxin = 16'sh7abc; pyin = -16'sd999; pzin = 16'sh1234;
        rxin = 16'sh4000; ryin = -16'sh4000; rzin = 16'sd77;
        lxin = 16'sh0fff; lyin = -16'sd5; lzin = 16'sh0333;
    endtask

    task automatic random_ray(input int tag);
        int px, py, pz, rx, ry, rz, lx, ly, lz, mh, ml, mlat;
        px = int'($urandom_range(0, 3072)) - 1536;
        py = int'($urandom_range(0, 3072)) - 1536;
        pz = int'($urandom_range(0, 3072)) - 1536;
        rx = int'($urandom_range(0, 32768)) - 16384;
        ry = int'($urandom_range(0, 32768)) - 16384;
        rz = int'($urandom_range(0, 32768)) - 16384;
        lx = int'($urandom_range(0, 8192)) - 4096;
        ly = int'($urandom_range(0, 8192)) - 4096;
        lz = int'($urandom_range(0, 8192)) - 4096;
        model(px, py, pz, rx, ry, rz, lx, ly, lz, mh, ml, mlat);
        issue(px, py, pz, rx, ry, rz, lx, ly, lz, mh, ml, 0, mlat, 1'b0, tag);
    endtask

    initial begin
        fork
            begin : driver
                repeat (3) @(negedge clk);
                check("reset_hit", int'(hit), 0, 0);
                check("reset_light", int'(light), 0, 0);
                check("reset_valid", int'(valid), 0, 0);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);

                // Head-on, through the hole, back-lit.
                issue(512, 0, -1280, 0, 0, 16384, 0, 0, -4096, 1, 4096, LTOL, HEAD_LAT, 1'b0, 1);
                repeat (14) @(negedge clk);
                issue(0, 0, -1280, 0, 0, 16384, 0, 0, -4096, 0, 0, 0, MISS_LAT, 1'b0, 2);
                repeat (14) @(negedge clk);
                issue(512, 0, -1280, 0, 0, 16384, 0, 0, 4096, 1, -4096, LTOL, HEAD_LAT, 1'b0, 3);
                repeat (14) @(negedge clk);

                // Restart: hole ray aborted 5 cycles in by the head-on ray.
                issue(0, 0, -1280, 0, 0, 16384, 0, 0, -4096, 0, 0, 0, MISS_LAT, 1'b0, 4);
                repeat (4) @(negedge clk);
                issue(512, 0, -1280, 0, 0, 16384, 0, 0, -4096, 1, 4096, LTOL, HEAD_LAT, 1'b1, 5);
                repeat (14) @(negedge clk);

                // Reset mid-march while hit/light still hold the head-on result.
                issue(0, 0, -1280, 0, 0, 16384, 0, 0, -4096, 0, 0, 0, MISS_LAT, 1'b0, 6);
                repeat (4) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_hit", int'(hit), 0, 0);
                check("async_rst_light", int'(light), 0, 0);
                check("async_rst_valid", int'(valid), 0, 0);
                sb.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (20) @(negedge clk);
                check("post_rst_hit", int'(hit), 0, 0);

                // Cadence: one ray every 16 cycles.
                for (int k = 0; k < 64; k++) begin
                    random_ray(100 + k);
                    repeat (14) @(negedge clk);
                end
                repeat (20) @(negedge clk);
                check("scoreboard_drained", sb.size(), 0, 0);
            end
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (valid) begin
                            if (sb.size() == 0) begin
                                check("unexpected_valid", 1, 0, 0);
                            end else begin
                                e = sb.pop_front();
                                check($sformatf("hit[%0d]", e.tag), int'(hit), e.hit, 0);
                                check($sformatf("light[%0d]", e.tag), int'(light), e.light, e.tol);
                                check($sformatf("latency[%0d]", e.tag), cyc, e.exp_cyc, 0);
                            end
                        end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                            check($sformatf("valid_timeout[%0d]", sb[0].tag), cyc, sb[0].exp_cyc, 0);
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
